minibyte_seq_alu: RTL

MINIBYTE_SEQ_ALU -- requirements
Module: minibyte_seq_alu

---
 rtl/minibyte_seq_alu.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/minibyte_seq_alu.sv
// Sequential WIDTH-bit ALU with IDLE/EXEC/DONE control; multiply datapath built only with MINIBYTE_ALU_MUL_EN.
// Latency: 1 cycle for most ops, shift-count cycles for rotate-by-B, WIDTH cycles for multiply.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so accepts are >= 2 cycles apart.
module minibyte_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             flag_z_out,
  output logic             flag_n_out,
  output logic             flag_c_out,
  output logic             flag_v_out,
  output logic             busy_out
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_PASS_A = 4'h0;
  localparam logic [3:0] OP_PASS_B = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_OR     = 4'h5;
  localparam logic [3:0] OP_XOR    = 4'h6;
  localparam logic [3:0] OP_ROT1   = 4'h7;
  localparam logic [3:0] OP_ROLN   = 4'h8;
  localparam logic [3:0] OP_MUL    = 4'h9;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

  logic [1:0]       state;
  logic             rdy_q;
  logic [WIDTH-1:0] a_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_q;
  logic             z_q, n_q, c_q, v_q;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    rot_cnt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c;
  logic             exec_last;

`ifdef MINIBYTE_ALU_MUL_EN
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
`endif

  // rdy_q keeps in_ready low through reset and until the first edge after release
  assign in_ready   = rdy_q && (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy_out   = (state == EXEC);
  assign res_out    = res_q;
  assign flag_z_out = z_q;
  assign flag_n_out = n_q;
  assign flag_c_out = c_q;
  assign flag_v_out = v_q;

  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, a_in} + {1'b0, b_in};
  assign diff      = a_in - b_in;
  assign rot_cnt   = b_in[SW-1:0];
  assign exec_last = (cnt == CW'(1));

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_in)
      OP_PASS_A: alu_res = a_in;
      OP_PASS_B: alu_res = b_in;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a_in < b_in);
        alu_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND:  alu_res = a_in & b_in;
      OP_OR:   alu_res = a_in | b_in;
      OP_XOR:  alu_res = a_in ^ b_in;
      OP_ROT1: alu_res = b_in[WIDTH-1] ? rotl1(a_in) : rotr1(a_in);
      OP_ROLN: alu_res = a_in; // only reached with a zero shift count
      default: alu_res = '0;
    endcase
  end

  // Value the EXEC step would produce if this is its last cycle
  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
`ifdef MINIBYTE_ALU_MUL_EN
    prod_nxt = prod + (b_q[0] ? a_sh : '0);
`endif
    if (op_q == OP_ROLN) begin
      exec_res = rotl1(a_q);
    end
`ifdef MINIBYTE_ALU_MUL_EN
    else if (op_q == OP_MUL) begin
      exec_res = prod_nxt[WIDTH-1:0];
      exec_c   = |prod_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      a_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
`ifdef MINIBYTE_ALU_MUL_EN
      b_q   <= '0;
      a_sh  <= '0;
      prod  <= '0;
`endif
    end else begin
      rdy_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= a_in;
            op_q <= op_in;
`ifdef MINIBYTE_ALU_MUL_EN
            b_q  <= b_in;
            a_sh <= {{WIDTH{1'b0}}, a_in};
            prod <= '0;
`endif
            if (op_in == OP_ROLN && rot_cnt != '0) begin
              state <= EXEC;
              cnt   <= CW'(rot_cnt);
            end
`ifdef MINIBYTE_ALU_MUL_EN
            else if (op_in == OP_MUL) begin
              state <= EXEC;
              cnt   <= CW'(WIDTH);
            end
`endif
            else begin
              state <= DONE;
              res_q <= alu_res;
              z_q   <= (alu_res == '0);
              n_q   <= alu_res[WIDTH-1];
              c_q   <= alu_c;
              v_q   <= alu_v;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          a_q <= rotl1(a_q);
`ifdef MINIBYTE_ALU_MUL_EN
          prod <= prod_nxt;
          a_sh <= a_sh << 1;
          b_q  <= b_q >> 1;
`endif
          if (exec_last) begin
            state <= DONE;
            res_q <= exec_res;
            z_q   <= (exec_res == '0);
            n_q   <= exec_res[WIDTH-1];
            c_q   <= exec_c;
            v_q   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
